// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store at a time, fixed access latency,
// byte-lane stores, zero-extended byte loads, sticky out-of-range flag.

package data_mem_ctrl_pkg;
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        yumi;
    logic        valid;
    logic [31:0] read_data;
  } mem_out_s;
endpackage

// state | meaning
// IDLE  | waiting for a request; yumi mirrors request valid
// BUSY  | request captured, latency counter running down
// RESP  | access done, response held until the core acknowledges it
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o,
  output logic        addr_err_o
);

  localparam int  depth_lp = 2 ** addr_width_p;
  localparam bit  lat1_lp  = (latency_p == 1);
  localparam logic [2:0] cnt_load_lp = 3'(latency_p - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic        bnw_q, bnw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [depth_lp];

  // access source: straight from the request port on a latency-1 accept,
  // otherwise from the captured fields at the end of BUSY
  logic                    acc_fire;
  logic [31:0]             acc_addr;
  logic                    acc_wen;
  logic                    acc_bnw;
  logic [31:0]             acc_wdata;
  logic                    acc_oor;
  logic [addr_width_p-1:0] acc_idx;
  logic [1:0]              acc_lane;
  logic [31:0]             rd_word;
  logic                    accept;

  // request acceptance, access selection and read-data formation
  always_comb begin
    accept    = ~reset & (state_q == IDLE) & to_mem_i.valid;
    acc_fire  = 1'b0;
    acc_addr  = addr_q;
    acc_wen   = wen_q;
    acc_bnw   = bnw_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_fire  = accept & lat1_lp;
      acc_addr  = addr_i;
      acc_wen   = to_mem_i.wen;
      acc_bnw   = to_mem_i.byte_not_word;
      acc_wdata = to_mem_i.write_data;
    end else if (state_q == BUSY) begin
      acc_fire = ~reset & (cnt_q == 3'd1);
    end
    acc_oor  = |acc_addr[31:addr_width_p+2];
    acc_idx  = acc_addr[addr_width_p+1:2];
    acc_lane = acc_addr[1:0];
    rd_word  = mem[acc_idx];
  end

  // FSM next state, captured fields, response data and error flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    bnw_d   = bnw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = addr_i;
          wen_d   = to_mem_i.wen;
          bnw_d   = to_mem_i.byte_not_word;
          wdata_d = to_mem_i.write_data;
          cnt_d   = cnt_load_lp;
          state_d = lat1_lp ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RESP;
      end
      RESP: begin
        if (to_mem_i.yumi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc_fire) begin
      if (acc_wen || acc_oor) rdata_d = 32'd0;
      else if (acc_bnw)       rdata_d = {24'd0, rd_word[{acc_lane, 3'b000} +: 8]};
      else                    rdata_d = rd_word;
      if (acc_oor) err_d = 1'b1;
    end
  end

  // state and captured-field registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      bnw_q   <= bnw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM write port; acc_fire is already gated by reset, contents never cleared
  always_ff @(posedge clk) begin
    if (acc_fire && acc_wen && !acc_oor) begin
      if (acc_bnw) mem[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_wdata[7:0];
      else         mem[acc_idx] <= acc_wdata;
    end
  end

  assign from_mem_o.yumi      = accept;
  assign from_mem_o.valid     = (state_q == RESP);
  assign from_mem_o.read_data = rdata_q;
  assign addr_err_o           = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed and random loads/stores against a
// word-array reference model, plus a latency-1 instance for timing edges.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  mem_in_s     to_mem, to_mem1;
  logic [31:0] addr_in, addr_in1;
  mem_out_s    from_mem, from_mem1;
  logic        err, err1;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [16];
  logic        err_exp;

  always #5 clk = ~clk;

  data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) dut (
    .clk(clk), .reset(reset), .to_mem_i(to_mem), .addr_i(addr_in),
    .from_mem_o(from_mem), .addr_err_o(err));

  data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) dut1 (
    .clk(clk), .reset(reset), .to_mem_i(to_mem1), .addr_i(addr_in1),
    .from_mem_o(from_mem1), .addr_err_o(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    return (a >= 32'h0000_1000);
  endfunction

  // expected response and model update for one transaction
  function automatic logic [31:0] model_op(input bit wen, input bit bnw,
                                           input logic [31:0] a, input logic [31:0] wd);
    int w, lane;
    logic [31:0] word;
    if (is_oor(a)) return 32'd0;
    w    = int'(a / 4);
    lane = int'(a % 4);
    word = ref_mem[w];
    if (wen) begin
      if (bnw) begin
        word = word & ~(32'hFF << (8 * lane));
        word = word | ((wd & 32'hFF) << (8 * lane));
      end else begin
        word = wd;
      end
      ref_mem[w] = word;
      return 32'd0;
    end
    if (bnw) return (word >> (8 * lane)) & 32'hFF;
    return word;
  endfunction

  task automatic run_op(input bit wen, input bit bnw, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input bit hold,
                        output logic [31:0] rd);
    logic [31:0] exp, held;
    logic        err_before;
    err_before = err_exp;
    exp = model_op(wen, bnw, a, wd);
    if (is_oor(a)) err_exp = 1'b1;
    @(negedge clk);
    to_mem.valid = 1'b1; to_mem.wen = wen; to_mem.byte_not_word = bnw;
    to_mem.write_data = wd; to_mem.yumi = 1'b0; addr_in = a;
    #1 chk("accept_yumi", 32'(from_mem.yumi), 32'd1);
    @(negedge clk);
    if (!hold) to_mem.valid = 1'b0;
    #1;
    chk("busy_valid", 32'(from_mem.valid), 32'd0);
    chk("busy_yumi", 32'(from_mem.yumi), 32'd0);
    chk("busy_err", 32'(err), 32'(err_before));
    held = 32'd0;
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      #1;
      chk("resp_valid", 32'(from_mem.valid), 32'd1);
      chk("resp_yumi", 32'(from_mem.yumi), 32'd0);
      if (k == 0) begin
        chk("resp_data", from_mem.read_data, exp);
        chk("resp_err", 32'(err), 32'(err_exp));
        held = from_mem.read_data;
      end else begin
        chk("resp_hold", from_mem.read_data, held);
      end
      if (k == dly) begin
        to_mem.yumi  = 1'b1;
        to_mem.valid = 1'b0;
      end
    end
    @(negedge clk);
    to_mem.yumi = 1'b0;
    #1 chk("idle_valid", 32'(from_mem.valid), 32'd0);
    rd = held;
  endtask

  // store interrupted by reset while in BUSY: must never commit or respond
  task automatic reset_during_busy(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    to_mem.valid = 1'b1; to_mem.wen = 1'b1; to_mem.byte_not_word = 1'b0;
    to_mem.write_data = wd; to_mem.yumi = 1'b0; addr_in = a;
    #1 chk("rst_accept", 32'(from_mem.yumi), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_yumi_forced", 32'(from_mem.yumi), 32'd0);
    @(negedge clk);
    reset = 1'b0; to_mem.valid = 1'b0;
    err_exp = 1'b0;
    #1;
    chk("rst_no_resp", 32'(from_mem.valid), 32'd0);
    chk("rst_err_clear", 32'(err), 32'd0);
    @(negedge clk);
    #1 chk("rst_no_resp2", 32'(from_mem.valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] a;
  bit          wen_r, bnw_r;

  initial begin
    reset = 1'b1;
    to_mem  = '0; to_mem1  = '0;
    addr_in = '0; addr_in1 = '0;
    to_mem.valid = 1'b1;
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_yumi", 32'(from_mem.yumi), 32'd0);
    chk("reset_valid", 32'(from_mem.valid), 32'd0);
    chk("reset_data", from_mem.read_data, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0; to_mem.valid = 1'b0;

    // fill the model window with known words
    for (int i = 0; i < 16; i++)
      run_op(1'b1, 1'b0, 32'(i * 4), $urandom, 0, 1'b0, rd);

    // directed cases
    run_op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd);
    chk("store_rd_zero", rd, 32'd0);
    run_op(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd);
    chk("load_deadbeef", rd, 32'hDEADBEEF);
    run_op(1'b1, 1'b1, 32'h20, 32'hAAAA_AA11, 0, 1'b0, rd);
    run_op(1'b1, 1'b1, 32'h21, 32'h0000_0022, 0, 1'b0, rd);
    run_op(1'b1, 1'b1, 32'h22, 32'h5555_5533, 0, 1'b0, rd);
    run_op(1'b1, 1'b1, 32'h23, 32'h0000_0044, 0, 1'b0, rd);
    run_op(1'b0, 1'b0, 32'h20, 32'h0, 0, 1'b0, rd);
    chk("byte_assembled", rd, 32'h44332211);
    run_op(1'b0, 1'b1, 32'h22, 32'h0, 0, 1'b0, rd);
    chk("byte_load", rd, 32'h00000033);
    run_op(1'b0, 1'b0, 32'h13, 32'h0, 0, 1'b0, rd);
    chk("unaligned_word", rd, 32'hDEADBEEF);
    run_op(1'b0, 1'b0, 32'h0010_0000, 32'h0, 0, 1'b0, rd);
    chk("oor_load", rd, 32'd0);
    run_op(1'b1, 1'b0, 32'h8000_0010, 32'h1234_5678, 0, 1'b0, rd);
    run_op(1'b0, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd);
    chk("oor_store_dropped", rd, 32'hDEADBEEF);

    // reset while a store is pending, then prove nothing was written
    reset_during_busy(32'h10, 32'h0BAD_0BAD);
    run_op(1'b0, 1'b0, 32'h10, 32'h0, 1, 1'b0, rd);
    chk("rst_store_lost", rd, 32'hDEADBEEF);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      wen_r = 1'($urandom_range(0, 1));
      bnw_r = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      run_op(wen_r, bnw_r, a, $urandom, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), rd);
    end

    // latency-1 instance: response in T+1, next accept no earlier than T+2
    @(negedge clk);
    to_mem1.valid = 1'b1; to_mem1.wen = 1'b1; to_mem1.byte_not_word = 1'b0;
    to_mem1.write_data = 32'hCAFEF00D; addr_in1 = 32'h4;
    #1 chk("l1_accept", 32'(from_mem1.yumi), 32'd1);
    @(negedge clk);
    to_mem1.wen = 1'b0; to_mem1.yumi = 1'b1;
    #1;
    chk("l1_valid_t1", 32'(from_mem1.valid), 32'd1);
    chk("l1_store_rd", from_mem1.read_data, 32'd0);
    chk("l1_no_accept_t1", 32'(from_mem1.yumi), 32'd0);
    @(negedge clk);
    to_mem1.yumi = 1'b0;
    #1;
    chk("l1_idle_valid", 32'(from_mem1.valid), 32'd0);
    chk("l1_accept_t2", 32'(from_mem1.yumi), 32'd1);
    @(negedge clk);
    to_mem1.valid = 1'b0;
    #1;
    chk("l1_load_valid", 32'(from_mem1.valid), 32'd1);
    chk("l1_load_data", from_mem1.read_data, 32'hCAFEF00D);
    chk("l1_err", 32'(err1), 32'd0);
    to_mem1.yumi = 1'b1;
    @(negedge clk);
    to_mem1.yumi = 1'b0;
    #1 chk("l1_done", 32'(from_mem1.valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller sitting directly downstream of the pipelined core's execute stage. Accepts one load/store request at a time over the core's `mem_in_s` valid/yumi handshake and performs the access after a fixed, parameterised latency. Returns the result over `mem_out_s`, holding the response until the core acknowledges it. Owns the byte-addressed data RAM, byte-lane writes, and out-of-range detection.

## Interface
Parameters:
- `addr_width_p`, 10: log2 of RAM depth in 32-bit words (depth = 2^addr_width_p words).
- `latency_p`, 2: cycles from request acceptance to first response-valid cycle; legal range 1..7.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `to_mem_i`  in  `mem_in_s`  request from core: `write_data`, `valid`, `wen`, `byte_not_word`, `yumi` (response acknowledge).
- `addr_i`  in  32  byte address of the request, qualified by `to_mem_i.valid`.
- `from_mem_o`  out  `mem_out_s`  `yumi` (request accepted), `valid` (response available), `read_data` (32).
- `addr_err_o`  out  1  sticky flag, set by any accepted out-of-range request.

## Operation
- States: IDLE, BUSY, RESP. Reset → IDLE.
- IDLE: `from_mem_o.yumi` = `to_mem_i.valid` (combinational). On yumi, capture `addr_i`, `wen`, `byte_not_word`, `write_data`; load the down-counter with `latency_p-1`.
  - If `latency_p`=1, go directly to RESP; otherwise go to BUSY.
- BUSY: decrement the counter each cycle. When it reads 1, perform the access on that edge and go to RESP. `to_mem_i.valid` is ignored; yumi = 0.
- RESP: `from_mem_o.valid`=1 and `read_data` is held stable. On `to_mem_i.yumi`=1, go to IDLE on the next edge.
  - A new request is never accepted in the same cycle as a response yumi; there is a minimum one-cycle IDLE bubble.
- Address decode:
  - word index = `addr_i[addr_width_p+1:2]`; byte lane = `addr_i[1:0]`.
  - Out of range: any of `addr_i[31:addr_width_p+2]` nonzero.
- Word access: `addr_i[1:0]` is ignored (forced word-aligned). Store writes all 32 bits; load returns the full word.
- Byte access:
  - Store writes only lane `addr_i[1:0]` with `write_data[7:0]`; lane 0 = bits [7:0], little-endian.
  - Load returns the selected byte zero-extended to 32 bits.
- Stores also produce a response; `read_data`=0 for stores.
- Out-of-range request: still accepted and completes normally.
  - Store is dropped (RAM unchanged); load returns 0.
  - `addr_err_o` sets on the access edge and clears only on reset.
- RAM contents are not initialised or cleared by reset.

## Timing
- Request accepted in cycle T, meaning `valid`&`yumi` high in T.
- `from_mem_o.valid` first high in cycle T+`latency_p` and stays high until the cycle with `to_mem_i.yumi`=1 inclusive.
- Earliest next acceptance: cycle after the response yumi.
- RAM read and write both occur on the edge entering RESP. A load observes every store whose response was already issued.
- Reset values:
  - `from_mem_o.valid`=0, `from_mem_o.yumi`=0 (during reset cycles yumi is forced 0), `read_data`=0, `addr_err_o`=0.
  - Counter = 0; captured request fields = 0.
- Reset mid-operation (BUSY or RESP): pending request abandoned.
  - An uncommitted store (still in BUSY) never writes.
  - No response is produced; the next cycle is IDLE.
- Core holding `valid` high across acceptance: no second acceptance occurs, because yumi is only asserted in IDLE.
- Response `yumi` asserted in the same cycle `valid` first rises: legal; the transaction finishes in one RESP cycle.

## Test plan
- `latency_p`=2. Word store 0xDEADBEEF @0x10, then word load @0x10.
  - Store: yumi at T, valid at T+2.
  - Load returns 0xDEADBEEF at T'+2.
- Byte stores 0x11/0x22/0x33/0x44 to 0x20..0x23, then word load @0x20 → 0x44332211.
  - Byte load @0x22 → 0x00000033.
- Word load @0x13 → same word as @0x10.
  - Load @0x00100000 (out of range) → read_data 0 and `addr_err_o`=1 from the access edge onward; RAM unchanged.
- Core delays response yumi 5 cycles → valid and read_data held constant all 5 cycles.
  - Request valid held high during BUSY/RESP → no extra yumi.
- Store issued, `reset` pulsed during BUSY → no response; later load of that address returns the prior contents.
  - `addr_err_o`=0 after reset.
- `latency_p`=1 build: yumi at T, valid at T+1. Response yumi at T+1; new request accepted no earlier than T+2.
